complex_upconverter: RTL and testbench
======================================

COMPLEX_UPCONVERTER -- requirements
Module: complex_upconverter

Interface
REQ-001 The block SHALL declare parameter PHASE_W, default 16, meaning phase accumulator and phase increment width in bits.
REQ-002 The block SHALL declare parameter LUT_BITS, default 8, meaning number of accumulator MSBs used as LO table index.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset; both ports are listed first below.
REQ-004 The block SHALL have port clock, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: baseband sample present this cycle.
REQ-007 The block SHALL have port sig_baseband_real, input, signed 10 bits: baseband I sample.
REQ-008 The block SHALL have port sig_baseband_imag, input, signed 10 bits: baseband Q sample.
REQ-009 The block SHALL have port phase_inc_in, input, PHASE_W bits: new unsigned phase increment per sample.
REQ-010 The block SHALL have port inc_load, input, 1 bit: capture phase_inc_in into the increment register.
REQ-011 The block SHALL have port phase_clear, input, 1 bit: zero the phase accumulator.
REQ-012 The block SHALL have port sig_modulated_real, output, signed 22 bits: upconverted I.
REQ-013 The block SHALL have port sig_modulated_imag, output, signed 22 bits: upconverted Q.
REQ-014 The block SHALL have port out_valid, output, 1 bit: output sample valid this cycle.

Function
REQ-015 The block SHALL compute, per accepted sample, out = baseband x LO with LO = exp(+j*theta): real = br*lr - bi*li; imag = br*li + bi*lr.
REQ-016 The block SHALL use idx = top LUT_BITS bits of the accumulator, with lr = round(511*cos(2*pi*idx/2^LUT_BITS)) and li = round(511*sin(2*pi*idx/2^LUT_BITS)), signed 10 bits; a full table or quarter-wave symmetry is acceptable, provided the values are bit-exact.
REQ-017 The block SHALL compute the products as full-precision signed 20 bits and the sum/difference as sign-extended signed 22 bits, with no rounding, truncation or saturation.
REQ-018 The block SHALL be a 3-stage pipeline: S1 registers the sample and LO; S2 registers the four products; S3 registers the sum/difference into the outputs.
REQ-019 The block SHALL assert out_valid exactly 3 cycles after the in_valid cycle, forming a valid bit per stage.
REQ-020 The block SHALL advance the accumulator by the increment register (modulo 2^PHASE_W) only on cycles with in_valid=1; otherwise it holds.
REQ-021 The block SHALL use the pre-update accumulator value as the phase for the sample accepted in that cycle.
REQ-022 With phase_clear=1, the block SHALL load the accumulator with 0 if in_valid=0, or with the increment if in_valid=1; the sample in that cycle uses phase 0.
REQ-023 With inc_load=1, the block SHALL update the increment register at the clock edge; a sample accepted in the same cycle advances by the old increment.
REQ-024 The block SHALL hold its outputs at their last value while out_valid=0; the pipeline data registers need not be gated.
REQ-025 The block SHALL provide no backpressure: every in_valid sample is accepted.

Reset
REQ-026 With rst=1 at a clock edge, the block SHALL clear the accumulator, increment register, all stage valid bits, out_valid and both outputs to 0.
REQ-027 Reset SHALL discard in-flight samples: out_valid is 0 the cycle after rst, and the next out_valid occurs 3 cycles after the first post-reset in_valid.
REQ-028 With rst=1, the block SHALL ignore in_valid, inc_load and phase_clear.

Verification
REQ-029 Reset test: hold rst 2 cycles mid-stream -> out_valid=0, outputs=0, and the next sample uses phase 0.
REQ-030 Zero-phase test: inc=0, one sample (100,0) -> 3 cycles later real=51100, imag=0, with out_valid for exactly 1 cycle.
REQ-031 Quarter-turn test: inc=0x4000 with four back-to-back (100,0) samples -> outputs (51100,0), (0,51100), (-51100,0), (0,-51100).
REQ-032 Extremes test: idx 0, sample (-512,-512) -> (-261632,-261632); idx 64, sample (-512,511) -> (-261121,-261632).
REQ-033 Gapped-valid test: valid pattern 1,0,0,1,1 with inc=0x4000 -> out_valid pattern equals the input pattern delayed 3 cycles, and the phases of the three samples are idx 0, 64, 128.
REQ-034 Simultaneous-control test: phase_clear and inc_load with in_valid in the same cycle -> that sample uses idx 0, and the next sample uses the old increment.

Source files
------------

// File: rtl/complex_upconverter.sv
// complex_upconverter: multiplies a baseband I/Q stream by exp(+j*theta) from a phase-accumulated LO table
// ports: clock, rst (sync, active high)
//        in_valid, sig_baseband_real/imag (s10)  -> baseband sample
//        phase_inc_in, inc_load, phase_clear      -> LO phase control
//        sig_modulated_real/imag (s22), out_valid -> upconverted sample, 3 cycles later
module complex_upconverter #(
  parameter int PHASE_W = 16,
  parameter int LUT_BITS = 8
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic signed [9:0]         sig_baseband_real,
  input  logic signed [9:0]         sig_baseband_imag,
  input  logic [PHASE_W-1:0]        phase_inc_in,
  input  logic                      inc_load,
  input  logic                      phase_clear,
  output logic signed [21:0]        sig_modulated_real,
  output logic signed [21:0]        sig_modulated_imag,
  output logic                      out_valid
);
  // round(511*sin(2*pi*k/256)) for k = 0..64; the rest of the circle comes from symmetry
  localparam logic [8:0] SIN_Q [0:64] = '{
    9'd0,   9'd13,  9'd25,  9'd38,  9'd50,  9'd63,  9'd75,  9'd87,  9'd100, 9'd112,
    9'd124, 9'd136, 9'd148, 9'd160, 9'd172, 9'd184, 9'd196, 9'd207, 9'd218, 9'd230,
    9'd241, 9'd252, 9'd263, 9'd273, 9'd284, 9'd294, 9'd304, 9'd314, 9'd324, 9'd334,
    9'd343, 9'd352, 9'd361, 9'd370, 9'd379, 9'd387, 9'd395, 9'd403, 9'd410, 9'd418,
    9'd425, 9'd432, 9'd438, 9'd445, 9'd451, 9'd456, 9'd462, 9'd467, 9'd472, 9'd477,
    9'd481, 9'd485, 9'd489, 9'd492, 9'd496, 9'd499, 9'd501, 9'd503, 9'd505, 9'd507,
    9'd509, 9'd510, 9'd510, 9'd511, 9'd511
  };
  function automatic logic signed [9:0] sin_lut(input logic [7:0] i);
    logic [6:0] m;
    logic signed [9:0] v;
    m = i[6] ? 7'(7'd64 - {1'b0, i[5:0]}) : {1'b0, i[5:0]};
    v = $signed({1'b0, SIN_Q[m]});
    return i[7] ? -v : v;
  endfunction
  logic [PHASE_W-1:0] acc, inc, phase;
  logic [7:0] idx;
  logic v1, v2, v3;
  logic signed [9:0] br1, bi1, lr1, li1;
  logic signed [19:0] p_rr, p_ii, p_ri, p_ir;
  // the table has 256 points; narrower indices are scaled up to the same angle
  if (LUT_BITS >= 8) begin : g_idx_full
    assign idx = phase[PHASE_W-1 -: 8];
  end else begin : g_idx_narrow
    assign idx = {phase[PHASE_W-1 -: LUT_BITS], {(8-LUT_BITS){1'b0}}};
  end
  // a clear lands on the same cycle's sample, so its phase is forced to zero
  assign phase = phase_clear ? '0 : acc;
  assign out_valid = v3;
  always_ff @(posedge clock) begin
    if (rst) begin
      acc <= '0;
      inc <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      sig_modulated_real <= '0;
      sig_modulated_imag <= '0;
    end else begin
      if (inc_load) inc <= phase_inc_in;
      if (in_valid) acc <= phase + inc;
      else if (phase_clear) acc <= '0;
      v1 <= in_valid;
      v2 <= v1;
      v3 <= v2;
      if (v2) begin
        sig_modulated_real <= 22'(p_rr) - 22'(p_ii);
        sig_modulated_imag <= 22'(p_ri) + 22'(p_ir);
      end
    end
  end
  always_ff @(posedge clock) begin
    br1 <= sig_baseband_real;
    bi1 <= sig_baseband_imag;
    lr1 <= sin_lut(idx + 8'd64);
    li1 <= sin_lut(idx);
    p_rr <= 20'(br1) * 20'(lr1);
    p_ii <= 20'(bi1) * 20'(li1);
    p_ri <= 20'(br1) * 20'(li1);
    p_ir <= 20'(bi1) * 20'(lr1);
  end
endmodule

// File: tb/tb_complex_upconverter.sv
// tb_complex_upconverter: directed vector table plus reset sequence for complex_upconverter
module tb_complex_upconverter;
  logic clock = 1'b0;
  logic rst, in_valid, inc_load, phase_clear, out_valid;
  logic signed [9:0] br, bi;
  logic [15:0] inc_in;
  logic signed [21:0] mr, mi;
  int n_run = 0;
  int n_fail = 0;
  typedef struct {
    int v, br, bi, inc, ld, clr;
    int ev, er, ei;
  } vec_t;
  vec_t tab [36];
  complex_upconverter #(.PHASE_W(16), .LUT_BITS(8)) dut (
    .clock(clock), .rst(rst), .in_valid(in_valid),
    .sig_baseband_real(br), .sig_baseband_imag(bi),
    .phase_inc_in(inc_in), .inc_load(inc_load), .phase_clear(phase_clear),
    .sig_modulated_real(mr), .sig_modulated_imag(mi), .out_valid(out_valid)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic chk_out(input string nm, input int ev, input int er, input int ei);
    chk({nm, " valid"}, 64'(out_valid), 64'(ev));
    chk({nm, " real"}, 64'(mr), 64'(er));
    chk({nm, " imag"}, 64'(mi), 64'(ei));
  endtask
  initial begin
    // zero phase, one sample
    tab[0]  = '{1, 100, 0, 0, 0, 0, 0, 0, 0};
    tab[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    tab[2]  = '{0, 0, 0, 0, 0, 0, 1, 51100, 0};
    tab[3]  = '{0, 0, 0, 0, 0, 0, 0, 51100, 0};
    // quarter turn per sample
    tab[4]  = '{0, 0, 0, 'h4000, 1, 1, 0, 51100, 0};
    tab[5]  = '{1, 100, 0, 0, 0, 0, 0, 51100, 0};
    tab[6]  = '{1, 100, 0, 0, 0, 0, 0, 51100, 0};
    tab[7]  = '{1, 100, 0, 0, 0, 0, 1, 51100, 0};
    tab[8]  = '{1, 100, 0, 0, 0, 0, 1, 0, 51100};
    tab[9]  = '{0, 0, 0, 0, 0, 0, 1, -51100, 0};
    tab[10] = '{0, 0, 0, 0, 0, 0, 1, 0, -51100};
    tab[11] = '{0, 0, 0, 0, 0, 0, 0, 0, -51100};
    // extremes at idx 0 and 64
    tab[12] = '{1, -512, -512, 0, 0, 1, 0, 0, -51100};
    tab[13] = '{1, -512, 511, 0, 0, 0, 0, 0, -51100};
    tab[14] = '{0, 0, 0, 0, 0, 0, 1, -261632, -261632};
    tab[15] = '{0, 0, 0, 0, 0, 0, 1, -261121, -261632};
    tab[16] = '{0, 0, 0, 0, 0, 0, 0, -261121, -261632};
    // gapped valid 1,0,0,1,1
    tab[17] = '{1, 100, 0, 0, 0, 1, 0, -261121, -261632};
    tab[18] = '{0, 0, 0, 0, 0, 0, 0, -261121, -261632};
    tab[19] = '{0, 0, 0, 0, 0, 0, 1, 51100, 0};
    tab[20] = '{1, 100, 0, 0, 0, 0, 0, 51100, 0};
    tab[21] = '{1, 100, 0, 0, 0, 0, 0, 51100, 0};
    tab[22] = '{0, 0, 0, 0, 0, 0, 1, 0, 51100};
    tab[23] = '{0, 0, 0, 0, 0, 0, 1, -51100, 0};
    // clear + load + valid together: idx 0, then old inc (idx 64), then new inc (idx 96)
    tab[24] = '{1, 100, 0, 'h2000, 1, 1, 0, -51100, 0};
    tab[25] = '{1, 100, 0, 0, 0, 0, 0, -51100, 0};
    tab[26] = '{1, 100, 0, 0, 0, 0, 1, 51100, 0};
    tab[27] = '{0, 0, 0, 0, 0, 0, 1, 0, 51100};
    tab[28] = '{0, 0, 0, 0, 0, 0, 1, -36100, 36100};
    tab[29] = '{0, 0, 0, 0, 0, 0, 0, -36100, 36100};
    // fine step: idx 0 and idx 1 with a complex sample
    tab[30] = '{0, 0, 0, 'h0100, 1, 1, 0, -36100, 36100};
    tab[31] = '{1, 100, -50, 0, 0, 0, 0, -36100, 36100};
    tab[32] = '{1, 100, -50, 0, 0, 0, 0, -36100, 36100};
    tab[33] = '{0, 0, 0, 0, 0, 0, 1, 51100, -25550};
    tab[34] = '{0, 0, 0, 0, 0, 0, 1, 51750, -24250};
    tab[35] = '{0, 0, 0, 0, 0, 0, 0, 51750, -24250};
    rst = 1'b1;
    in_valid = 1'b0;
    inc_load = 1'b0;
    phase_clear = 1'b0;
    br = '0;
    bi = '0;
    inc_in = '0;
    step();
    step();
    chk_out("reset", 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 36; i++) begin
      in_valid = tab[i].v != 0;
      br = 10'(tab[i].br);
      bi = 10'(tab[i].bi);
      inc_in = 16'(tab[i].inc);
      inc_load = tab[i].ld != 0;
      phase_clear = tab[i].clr != 0;
      step();
      chk_out($sformatf("row%0d", i), tab[i].ev, tab[i].er, tab[i].ei);
    end
    // reset mid-stream with samples in flight and in_valid held high
    in_valid = 1'b1;
    br = 10'sd100;
    bi = 10'sd0;
    inc_in = 16'h4000;
    inc_load = 1'b1;
    phase_clear = 1'b0;
    step();
    inc_load = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk_out("rst cycle1", 0, 0, 0);
    step();
    chk_out("rst cycle2", 0, 0, 0);
    rst = 1'b0;
    step();
    in_valid = 1'b0;
    chk("post-rst v a", 64'(out_valid), 64'd0);
    step();
    chk("post-rst v b", 64'(out_valid), 64'd0);
    step();
    chk_out("post-rst sample", 1, 51100, 0);
    step();
    chk_out("post-rst hold", 0, 51100, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
